// File: rtl/rtl8211f_gmii_tx.sv
// GMII transmit framer for the RTL8211F: preamble/SFD, payload, zero padding,
// FCS and inter-frame gap, plus frame and abort counters for the register map.
module rtl8211f_gmii_tx #(
  parameter int MIN_PAYLOAD = 60,
  parameter int MAX_PAYLOAD = 1514,
  parameter int IFG_BYTES   = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        TxEn,
  output logic [7:0]  TxD,
  output logic        TxErr,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;

  localparam logic [10:0] MIN_P = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P = 11'(MAX_PAYLOAD);

  state_t      state_reg;
  logic [10:0] cnt_reg;
  logic [31:0] crc_reg;
  logic        tx_en_reg;
  logic        tx_err_reg;
  logic [7:0]  txd_reg;
  logic        fin_good_reg;
  logic        fin_err_reg;
  logic [15:0] frame_cnt_reg;
  logic [7:0]  err_cnt_reg;

  logic [10:0] cnt_next;
  logic [7:0]  data_rev;
  logic [7:0]  fcs_raw;
  logic [7:0]  fcs_byte;
  logic [4:0]  fcs_hi;
  logic [31:0] crc_data_next;
  logic [31:0] crc_pad_next;

  // MSB-first CRC-32 over a bit-reversed byte, matching the receive path.
  function automatic logic [31:0] crc32_8b(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i])
        r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else
        r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rev
      assign data_rev[gi] = tx_data[7-gi];
      assign fcs_byte[gi] = fcs_raw[7-gi];
    end
  endgenerate

  assign cnt_next      = cnt_reg + 11'd1;
  assign fcs_hi        = 5'd31 - {cnt_reg[1:0], 3'b000};
  assign fcs_raw       = ~crc_reg[fcs_hi -: 8];
  assign crc_data_next = crc32_8b(data_rev, crc_reg);
  assign crc_pad_next  = crc32_8b(8'h00, crc_reg);

  assign tx_ready  = (state_reg == DATA);
  assign busy      = (state_reg != IDLE);
  assign TxEn      = tx_en_reg;
  assign TxD       = txd_reg;
  assign TxErr     = tx_err_reg;
  assign frame_cnt = frame_cnt_reg;
  assign err_cnt   = err_cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      crc_reg       <= 32'hFFFFFFFF;
      tx_en_reg     <= 1'b0;
      tx_err_reg    <= 1'b0;
      txd_reg       <= 8'h00;
      fin_good_reg  <= 1'b0;
      fin_err_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_en_reg  <= 1'b0;
          tx_err_reg <= 1'b0;
          txd_reg    <= 8'h00;
          if (tx_valid) begin
            state_reg <= PREAMBLE;
            tx_en_reg <= 1'b1;
            txd_reg   <= 8'h55;
            cnt_reg   <= '0;
            crc_reg   <= 32'hFFFFFFFF;
          end
        end

        PREAMBLE: begin
          if (cnt_reg == 11'd6) begin
            txd_reg   <= 8'hD5;
            cnt_reg   <= '0;
            state_reg <= DATA;
          end else begin
            txd_reg <= 8'h55;
            cnt_reg <= cnt_next;
          end
        end

        DATA: begin
          // Bubble or oversize: one error cycle, offending byte dropped.
          if (!tx_valid || (cnt_reg == MAX_P && !tx_last)) begin
            tx_err_reg  <= 1'b1;
            txd_reg     <= 8'h00;
            fin_err_reg <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= IFG;
          end else begin
            txd_reg <= tx_data;
            crc_reg <= crc_data_next;
            cnt_reg <= cnt_next;
            if (tx_last) begin
              if (cnt_next < MIN_P) begin
                state_reg <= PAD;
              end else begin
                cnt_reg   <= '0;
                state_reg <= FCS;
              end
            end
          end
        end

        PAD: begin
          txd_reg <= 8'h00;
          crc_reg <= crc_pad_next;
          if (cnt_next >= MIN_P) begin
            cnt_reg   <= '0;
            state_reg <= FCS;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        FCS: begin
          txd_reg <= fcs_byte;
          cnt_reg <= cnt_next;
          if (cnt_reg[1:0] == 2'd3) begin
            fin_good_reg <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= IFG;
          end
        end

        IFG: begin
          tx_en_reg  <= 1'b0;
          tx_err_reg <= 1'b0;
          txd_reg    <= 8'h00;
          // First IFG edge closes the frame: TxEn drops and counters update.
          if (fin_good_reg || fin_err_reg) begin
            if (fin_good_reg)
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (fin_err_reg && err_cnt_reg != 8'hFF)
              err_cnt_reg <= err_cnt_reg + 8'd1;
            fin_good_reg <= 1'b0;
            fin_err_reg  <= 1'b0;
          end else if (int'(cnt_reg) >= IFG_BYTES - 2) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtl8211f_gmii_tx.sv
// Directed bench for the GMII transmit framer: frame layout, padding, FCS,
// aborts, inter-frame gap and asynchronous reset.
module tb_rtl8211f_gmii_tx;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rstn;
  logic       sel;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_last;

  logic       a_ready, a_en, a_err, a_busy;
  logic [7:0] a_d;
  logic [15:0] a_fc;
  logic [7:0] a_ec;
  logic       b_ready, b_en, b_err, b_busy;
  logic [7:0] b_d;
  logic [15:0] b_fc;
  logic [7:0] b_ec;

  logic a_valid, b_valid;
  assign a_valid = drv_valid & ~sel;
  assign b_valid = drv_valid & sel;

  rtl8211f_gmii_tx dut (
    .clk(clk), .rstn(rstn), .tx_data(drv_data), .tx_valid(a_valid), .tx_last(drv_last),
    .tx_ready(a_ready), .TxEn(a_en), .TxD(a_d), .TxErr(a_err), .busy(a_busy),
    .frame_cnt(a_fc), .err_cnt(a_ec)
  );

  rtl8211f_gmii_tx #(.MIN_PAYLOAD(0)) dut_nopad (
    .clk(clk), .rstn(rstn), .tx_data(drv_data), .tx_valid(b_valid), .tx_last(drv_last),
    .tx_ready(b_ready), .TxEn(b_en), .TxD(b_d), .TxErr(b_err), .busy(b_busy),
    .frame_cnt(b_fc), .err_cnt(b_ec)
  );

  logic       m_ready, m_en, m_err, m_busy;
  logic [7:0] m_d;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_en    = sel ? b_en    : a_en;
  assign m_err   = sel ? b_err   : a_err;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_d     = sel ? b_d     : a_d;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture of the current/last TxEn burst as {TxErr, TxD}; gap_last is the
  // number of TxEn-low cycles preceding the latest burst.
  logic [8:0] cap [$];
  int low_run = 0;
  int gap_last = 0;
  logic prev_en = 1'b0;

  initial forever begin
    @(negedge clk);
    if (m_en) begin
      if (!prev_en) begin
        cap.delete();
        gap_last = low_run;
      end
      cap.push_back({m_err, m_d});
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_en = m_en;
  end

  logic [7:0] pl [0:2047];

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic send_frame(input int n, input int drop_after, input bit hold, input bit use_last);
    int i = 0;
    int guard = 0;
    bit acc;
    drv_valid = 1'b1;
    drv_data  = pl[0];
    drv_last  = use_last && (n == 1);
    while (i < n && i != drop_after) begin
      @(negedge clk);
      acc = m_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        if (i < n) begin
          drv_data = pl[i];
          drv_last = use_last && (i == n - 1);
        end
      end
      guard++;
      if (guard > 4000) begin
        check("send_timeout", i, n);
        break;
      end
    end
    if (!hold) begin
      drv_valid = 1'b0;
      drv_last  = 1'b0;
    end
    $display("tx frame: len=%0d drop_after=%0d accepted=%0d hold=%0d", n, drop_after, i, hold);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (!m_busy && !m_en) break;
    end
    check({tag, "_idle"}, 32'(k < 3000), 32'd1);
  endtask

  task automatic check_good(input string tag, input int n, input int minp);
    int p;
    int bad;
    logic [31:0] c;
    logic [7:0] e;
    logic [31:0] fcs_got;
    p = (n > minp) ? n : minp;
    c = 32'hFFFFFFFF;
    check({tag, "_len"}, cap.size(), 12 + p);
    if (cap.size() == 12 + p) begin
      bad = 0;
      for (int i = 0; i < 7; i++) if (cap[i] != 9'h055) bad++;
      check({tag, "_preamble"}, bad, 0);
      check({tag, "_sfd"}, 32'(cap[7]), 32'h0D5);
      bad = 0;
      for (int i = 0; i < p; i++) begin
        e = (i < n) ? pl[i] : 8'h00;
        if (cap[8+i] != {1'b0, e}) bad++;
        c = crc_upd(c, e);
      end
      for (int i = 0; i < 4; i++) if (cap[8+p+i][8]) bad++;
      check({tag, "_payload"}, bad, 0);
      fcs_got = {cap[11+p][7:0], cap[10+p][7:0], cap[9+p][7:0], cap[8+p][7:0]};
      check({tag, "_fcs"}, fcs_got, ~c);
    end
  endtask

  task automatic check_abort(input string tag, input int n_sent);
    int bad;
    check({tag, "_len"}, cap.size(), 9 + n_sent);
    if (cap.size() == 9 + n_sent) begin
      bad = 0;
      for (int i = 0; i < n_sent; i++) if (cap[8+i] != {1'b0, pl[i]}) bad++;
      check({tag, "_payload"}, bad, 0);
      check({tag, "_errcycle"}, 32'(cap[8+n_sent]), 32'h100);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int k;
    rstn = 1'b0; sel = 1'b0;
    drv_data = 8'h00; drv_valid = 1'b0; drv_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_txen", 32'(a_en), 0);
    check("rst_txd", 32'(a_d), 0);
    check("rst_txerr", 32'(a_err), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_ready", 32'(a_ready), 0);
    check("rst_frame_cnt", 32'(a_fc), 0);
    check("rst_err_cnt", 32'(a_ec), 0);

    // 60-byte frame 0x00..0x3B, also used as the loopback residue check
    for (int i = 0; i < 2048; i++) pl[i] = 8'(i);
    send_frame(60, -1, 0, 1);
    wait_idle("f60");
    check_good("f60", 60, 60);
    r = 32'hFFFFFFFF;
    for (int i = 8; i < cap.size(); i++) r = crc_upd(r, cap[i][7:0]);
    check("loop_residue", r, 32'hDEBB20E3);
    check("loop_nbytes", cap.size() - 8, 64);
    check("f60_frame_cnt", 32'(a_fc), 1);
    check("f60_err_cnt", 32'(a_ec), 0);

    // "123456789", padded to 60
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    send_frame(9, -1, 0, 1);
    wait_idle("pad9");
    check_good("pad9", 9, 60);
    check("pad9_frame_cnt", 32'(a_fc), 2);

    // Same payload with no padding: the well-known CRC-32 check value
    sel = 1'b1;
    send_frame(9, -1, 0, 1);
    wait_idle("nopad9");
    check("nopad9_len", cap.size(), 21);
    if (cap.size() == 21) begin
      check("nopad9_fcs0", 32'(cap[17]), 32'h026);
      check("nopad9_fcs1", 32'(cap[18]), 32'h039);
      check("nopad9_fcs2", 32'(cap[19]), 32'h0F4);
      check("nopad9_fcs3", 32'(cap[20]), 32'h0CB);
    end
    check("nopad9_frame_cnt", 32'(b_fc), 1);
    sel = 1'b0;

    // Underrun after byte 20
    for (int i = 0; i < 2048; i++) pl[i] = 8'(i * 7 + 3);
    send_frame(40, 20, 0, 1);
    wait_idle("under");
    check_abort("under", 20);
    check("under_err_cnt", 32'(a_ec), 1);
    check("under_frame_cnt", 32'(a_fc), 2);

    // Oversize: 1515 bytes with no tx_last
    send_frame(1515, -1, 0, 0);
    wait_idle("over");
    check_abort("over", 1514);
    check("over_err_cnt", 32'(a_ec), 2);

    // Largest legal frame
    send_frame(1514, -1, 0, 1);
    wait_idle("max");
    check_good("max", 1514, 60);
    check("max_frame_cnt", 32'(a_fc), 3);
    check("max_err_cnt", 32'(a_ec), 2);

    // Back-to-back with tx_valid held high
    for (int i = 0; i < 60; i++) pl[i] = 8'hA0 ^ 8'(i);
    send_frame(60, -1, 1, 1);
    send_frame(60, -1, 0, 1);
    wait_idle("b2b");
    check("b2b_gap", gap_last, 12);
    check_good("b2b", 60, 60);
    check("b2b_frame_cnt", 32'(a_fc), 5);

    // Reset during FCS byte 2
    send_frame(60, -1, 0, 1);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (cap.size() == 71) break;
    end
    check("rstfcs_reached", 32'(k < 200), 1);
    rstn = 1'b0;
    #1;
    check("rstfcs_txen", 32'(a_en), 0);
    check("rstfcs_busy", 32'(a_busy), 0);
    check("rstfcs_frame_cnt", 32'(a_fc), 0);
    check("rstfcs_err_cnt", 32'(a_ec), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    send_frame(9, -1, 0, 1);
    wait_idle("after_rst");
    check_good("after_rst", 9, 60);
    check("after_rst_frame_cnt", 32'(a_fc), 1);
    check("after_rst_err_cnt", 32'(a_ec), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
